// File: rtl/level_pkg.sv
// Shared constants for the dungeon room wall map: tile geometry, door
// placement, per-room door masks and interior wall rectangles.
package level_pkg;

    localparam int TILE_SHIFT = 5;
    localparam int H_TILES    = 20;
    localparam int V_TILES    = 15;
    localparam int NUM_ROOMS  = 7;
    localparam int MAX_RECTS  = 2;

    typedef logic [4:0] tile_t;
    typedef logic [2:0] room_t;

    // Door mask bit positions, packed as {N,E,S,W}
    localparam int DOOR_N = 3;
    localparam int DOOR_E = 2;
    localparam int DOOR_S = 1;
    localparam int DOOR_W = 0;
    typedef logic [3:0] door_mask_t;

    // Last tile index on each axis (the far border row/column)
    localparam tile_t TX_LAST = tile_t'(H_TILES - 1);
    localparam tile_t TY_LAST = tile_t'(V_TILES - 1);

    // Door gap tile coordinates
    localparam tile_t DOOR_NS_X0 = 5'd9;
    localparam tile_t DOOR_NS_X1 = 5'd10;
    localparam tile_t DOOR_EW_Y  = 5'd7;

    // Pixel extents of the visible screen
    localparam logic [9:0] SCREEN_W = 10'(H_TILES << TILE_SHIFT);
    localparam logic [9:0] SCREEN_H = 10'(V_TILES << TILE_SHIFT);

    // Room index with no map: solid wall everywhere
    localparam room_t ROOM_WALLED = room_t'(NUM_ROOMS);

    localparam door_mask_t DOOR_MASK [NUM_ROOMS] = '{
        4'b1000,   // room 0: N
        4'b1110,   // room 1: N,E,S
        4'b0001,   // room 2: W
        4'b1110,   // room 3: N,E,S
        4'b1001,   // room 4: N,W
        4'b0010,   // room 5: S
        4'b0010    // room 6: S
    };

    // Inclusive tile rectangle
    typedef struct packed {
        tile_t x0;
        tile_t x1;
        tile_t y0;
        tile_t y1;
    } rect_t;

    // x0 > x1 so it never matches: marks an unused rectangle slot
    localparam rect_t NO_RECT = '{x0: 5'd31, x1: 5'd0, y0: 5'd31, y1: 5'd0};

    localparam rect_t ROOM_RECTS [NUM_ROOMS][MAX_RECTS] = '{
        '{NO_RECT, NO_RECT},
        '{'{x0: 5'd12, x1: 5'd15, y0: 5'd3,  y1: 5'd5 }, NO_RECT},
        '{'{x0: 5'd9,  x1: 5'd10, y0: 5'd11, y1: 5'd12}, NO_RECT},
        '{'{x0: 5'd10, x1: 5'd10, y0: 5'd3,  y1: 5'd11}, NO_RECT},
        '{'{x0: 5'd8,  x1: 5'd11, y0: 5'd6,  y1: 5'd8 }, NO_RECT},
        '{'{x0: 5'd9,  x1: 5'd10, y0: 5'd6,  y1: 5'd9 }, NO_RECT},
        '{'{x0: 5'd4,  x1: 5'd5,  y0: 5'd6,  y1: 5'd7 },
          '{x0: 5'd14, x1: 5'd15, y0: 5'd6,  y1: 5'd7 }}
    };

    function automatic logic in_rect(tile_t tx, tile_t ty, rect_t r);
        return (tx >= r.x0) && (tx <= r.x1) && (ty >= r.y0) && (ty <= r.y1);
    endfunction

endpackage

// File: rtl/level_wall_rom_if.sv
// Pixel query bus for the wall map: requester drives position and room,
// map answers with combinational and registered wall flags.
interface level_wall_rom_if;
    import level_pkg::*;

    logic [9:0] DrawX;
    logic [9:0] DrawY;
    room_t      room;
    logic       bg_type;
    logic       bg_type_q;

    modport master (output DrawX, DrawY, room, input bg_type, bg_type_q);
    modport slave  (input DrawX, DrawY, room, output bg_type, bg_type_q);

endinterface

// File: rtl/room_tile_lookup.sv
// Tile-level wall lookup for one in-range tile of a valid room.
// Precedence: door gap (floor) > border (wall) > interior rectangle (wall).
module room_tile_lookup
    import level_pkg::*;
(
    input  tile_t tx,
    input  tile_t ty,
    input  room_t room,
    output logic  wall
);

    room_t      room_idx;
    door_mask_t mask;
    logic       ns_span;
    logic       door_gap;
    logic       border;
    logic       rect_hit;

    // Classify the tile: door gaps override the border, border overrides rectangles
    always_comb begin
        room_idx = (room < ROOM_WALLED) ? room : '0;
        mask     = DOOR_MASK[room_idx];
        ns_span  = (tx >= DOOR_NS_X0) && (tx <= DOOR_NS_X1);

        door_gap = (mask[DOOR_N] && (ty == '0)      && ns_span)
                || (mask[DOOR_S] && (ty == TY_LAST) && ns_span)
                || (mask[DOOR_E] && (tx == TX_LAST) && (ty == DOOR_EW_Y))
                || (mask[DOOR_W] && (tx == '0)      && (ty == DOOR_EW_Y));

        border = (tx == '0) || (tx == TX_LAST) || (ty == '0) || (ty == TY_LAST);

        rect_hit = 1'b0;
        for (int i = 0; i < MAX_RECTS; i++) begin
            if (in_rect(tx, ty, ROOM_RECTS[room_idx][i])) begin
                rect_hit = 1'b1;
            end
        end

        if (door_gap) begin
            wall = 1'b0;
        end else if (border) begin
            wall = 1'b1;
        end else begin
            wall = rect_hit;
        end
    end

endmodule

// File: rtl/level_wall_rom.sv
// Wall/floor map for the dungeon rooms. bg_type answers in the same cycle
// so callers can use it inside their own next-state logic; bg_type_q is a
// one-cycle registered copy for pipelined consumers.
module level_wall_rom
    import level_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    level_wall_rom_if.slave  bus
);

    tile_t tx;
    tile_t ty;
    logic  tile_wall;
    logic  force_wall;
    logic  bg_type;
    logic  bg_type_d;
    logic  bg_type_q;

    assign tx = bus.DrawX[9:TILE_SHIFT];
    assign ty = bus.DrawY[9:TILE_SHIFT];

    room_tile_lookup u_lookup (
        .tx   (tx),
        .ty   (ty),
        .room (bus.room),
        .wall (tile_wall)
    );

    // Offscreen positions (including parked/wrapped sprites) and the unmapped room read as wall
    always_comb begin
        force_wall = (bus.DrawX >= SCREEN_W) || (bus.DrawY >= SCREEN_H)
                  || (bus.room == ROOM_WALLED);
        bg_type    = force_wall | tile_wall;
        bg_type_d  = bg_type;
    end

    // One-cycle registered copy of the wall flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bg_type_q <= 1'b0;
        end else begin
            bg_type_q <= bg_type_d;
        end
    end

    assign bus.bg_type   = bg_type;
    assign bus.bg_type_q = bg_type_q;

endmodule

// File: tb/tb_level_wall_rom.sv
// Scoreboard bench for level_wall_rom: stimulus pushes expected results,
// a negedge monitor pops and compares both outputs.
module tb_level_wall_rom;

    logic clk;
    logic rst;

    level_wall_rom_if bif ();

    level_wall_rom dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int r;
        bit rst;
        bit exp;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference: rules of the room map written directly as arithmetic
    function automatic bit ref_wall(int x, int y, int r);
        int  tx, ty;
        bit  has_n, has_e, has_s, has_w;
        if (x >= 640 || y >= 480 || r == 7) return 1'b1;
        tx = x / 32;
        ty = y / 32;
        has_n = (r == 0 || r == 1 || r == 3 || r == 4);
        has_e = (r == 1 || r == 3);
        has_s = (r == 1 || r == 3 || r == 5 || r == 6);
        has_w = (r == 2 || r == 4);
        if (has_n && ty == 0  && (tx == 9 || tx == 10)) return 1'b0;
        if (has_s && ty == 14 && (tx == 9 || tx == 10)) return 1'b0;
        if (has_e && tx == 19 && ty == 7) return 1'b0;
        if (has_w && tx == 0  && ty == 7) return 1'b0;
        if (tx == 0 || tx == 19 || ty == 0 || ty == 14) return 1'b1;
        case (r)
            1: return (tx >= 12 && tx <= 15 && ty >= 3 && ty <= 5);
            2: return (tx >= 9 && tx <= 10 && ty >= 11 && ty <= 12);
            3: return (tx == 10 && ty >= 3 && ty <= 11);
            4: return (tx >= 8 && tx <= 11 && ty >= 6 && ty <= 8);
            5: return (tx >= 9 && tx <= 10 && ty >= 6 && ty <= 9);
            6: return (tx >= 4 && tx <= 5 && ty >= 6 && ty <= 7)
                   || (tx >= 14 && tx <= 15 && ty >= 6 && ty <= 7);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(int x, int y, int r, bit rs);
        item_t it;
        @(posedge clk);
        #1;
        bif.DrawX = x[9:0];
        bif.DrawY = y[9:0];
        bif.room  = r[2:0];
        rst       = rs;
        it.x   = x & 1023;
        it.y   = y & 1023;
        it.r   = r & 7;
        it.rst = rs;
        it.exp = ref_wall(it.x, it.y, it.r);
        q.push_back(it);
    endtask

    // Directed check with an explicitly required comb value
    task automatic drive_exp(int x, int y, int r, bit want);
        drive(x, y, r, 1'b0);
        q[q.size()-1].exp = want;
    endtask

    // Monitor: registered copy of the previous item, then comb value of the current one
    item_t prev;
    bit    pv = 1'b0;
    always begin
        item_t cur;
        bit    want_q;
        @(negedge clk);
        if (pv) begin
            want_q = prev.rst ? 1'b0 : prev.exp;
            checks++;
            if (bif.bg_type_q !== want_q) begin
                errors++;
                $display("FAIL bg_type_q room=%0d x=%0d y=%0d rst=%0b: got %b want %b",
                         prev.r, prev.x, prev.y, prev.rst, bif.bg_type_q, want_q);
            end
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (bif.bg_type !== cur.exp) begin
                errors++;
                $display("FAIL bg_type room=%0d x=%0d y=%0d: got %b want %b",
                         cur.r, cur.x, cur.y, bif.bg_type, cur.exp);
            end
            prev = cur;
            pv   = 1'b1;
        end else begin
            pv = 1'b0;
        end
    end

    initial begin
        rst       = 1'b1;
        bif.DrawX = '0;
        bif.DrawY = '0;
        bif.room  = '0;

        // Register path: reset, then release on a wall, then floor
        drive(64, 64, 0, 1'b1);
        drive_exp(0, 0, 0, 1'b1);
        drive_exp(64, 64, 0, 1'b0);

        // Room 0 floor and N door
        drive_exp(64, 64, 0, 1'b0);
        drive_exp(0, 0, 0, 1'b1);
        drive_exp(320, 0, 0, 1'b0);
        drive_exp(320, 470, 0, 1'b1);
        drive_exp(639, 240, 0, 1'b1);
        // Room 1 interior block and doors
        drive_exp(400, 100, 1, 1'b1);
        drive_exp(300, 200, 1, 1'b0);
        drive_exp(608, 224, 1, 1'b0);
        drive_exp(320, 465, 1, 1'b0);
        // Room 3 column, room 6 pillars
        drive_exp(330, 200, 3, 1'b1);
        drive_exp(360, 200, 3, 1'b0);
        drive_exp(140, 200, 6, 1'b1);
        drive_exp(320, 256, 6, 1'b0);
        // Range checks
        drive_exp(650, 100, 2, 1'b1);
        drive_exp(100, 700, 2, 1'b1);
        drive_exp(64, 64, 7, 1'b1);
        drive_exp(700, 700, 0, 1'b1);
        drive_exp(1023, 64, 0, 1'b1);
        drive_exp(0, 224, 2, 1'b0);
        drive_exp(639, 479, 0, 1'b1);

        // Reset mid-stream on a wall pixel, then resume capture
        drive(0, 0, 0, 1'b1);
        drive(0, 0, 0, 1'b0);

        // Sweep every tile centre of every room
        for (int r = 0; r < 7; r++)
            for (int ty = 0; ty < 15; ty++)
                for (int tx = 0; tx < 20; tx++)
                    drive(tx * 32 + 16, ty * 32 + 16, r, 1'b0);

        // Randomized traffic, mostly on-screen, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int x, y, r;
            bit rs;
            x  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
            y  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
            r  = $urandom_range(0, 7);
            rs = ($urandom_range(0, 31) == 0);
            drive(x, y, r, rs);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
